// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and the sequential ALU.
// Signal names keep the _i/_o direction as seen from the ALU (slave) side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] r_o;
    logic [3:0]       flags_o;

    modport master (
        output start_i, op_i, x_i, y_i,
        input  busy_o, done_o, r_o, flags_o
    );

    modport slave (
        input  start_i, op_i, x_i, y_i,
        output busy_o, done_o, r_o, flags_o
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake: single-cycle arithmetic/logic ops
// and an optional WIDTH-cycle shift-add multiplier. Result and flags hold until the next op.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_LDA = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_LDI = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_MUL = 4'hA
    } op_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v, alu_legal, is_mul;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] acc_step;

    // flags_o bit order: [3]=V [2]=N [1]=C [0]=Z
    function automatic logic [3:0] mk_flags(logic [WIDTH-1:0] r, logic c, logic v);
        return {v, r[M], c, (r == '0)};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case can infer a latch.
        sum       = {1'b0, bus.x_i} + {1'b0, bus.y_i};
        diff      = {1'b0, bus.x_i} - {1'b0, bus.y_i};
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        is_mul    = 1'b0;
        case (bus.op_i)
            OP_ADD: begin
                alu_r = sum[M:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.x_i[M] == bus.y_i[M]) && (sum[M] != bus.x_i[M]);
            end
            OP_SUB: begin
                alu_r = diff[M:0];
                alu_c = diff[WIDTH];
                alu_v = (bus.x_i[M] != bus.y_i[M]) && (diff[M] != bus.x_i[M]);
            end
            OP_LDA, OP_LDI: alu_r = bus.y_i;
            OP_AND: alu_r = bus.x_i & bus.y_i;
            OP_OR:  alu_r = bus.x_i | bus.y_i;
            OP_XOR: alu_r = bus.x_i ^ bus.y_i;
            OP_NOT: alu_r = ~bus.x_i;
            OP_SHL: begin
                alu_r = {bus.x_i[M-1:0], 1'b0};
                alu_c = bus.x_i[M];
            end
            OP_SHR: begin
                alu_r = {1'b0, bus.x_i[M:1]};
                alu_c = bus.x_i[0];
            end
            OP_MUL: begin
                alu_legal = 1'b0;
                is_mul    = MUL_EN;
            end
            default: alu_legal = 1'b0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (is_mul) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.x_i};
                        mplier_d = bus.y_i;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        // Illegal opcodes still pulse done so the controller never stalls.
                        done_d = 1'b1;
                        if (alu_legal) begin
                            r_d     = alu_r;
                            flags_d = mk_flags(alu_r, alu_c, alu_v);
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[M:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    r_d     = acc_step[M:0];
                    flags_d = mk_flags(acc_step[M:0], |acc_step[2*WIDTH-1:WIDTH], 1'b0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign bus.r_o     = r_q;
    assign bus.flags_o = flags_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = (state_q == S_MUL);
endmodule
